// File: rtl/pll_supervisor_if.sv
// Control and status bundle between the PLL supervisor and its environment.
// The slave side is the supervisor; the master side drives the lock and restart inputs.
interface pll_supervisor_if;
   logic       locked;
   logic       restart;
   logic       pll_resetb;
   logic       sys_reset;
   logic       ready;
   logic       fail;
   logic [3:0] retries;
   logic [7:0] lock_losses;
   logic [2:0] state;

   modport master (
      output locked, restart,
      input  pll_resetb, sys_reset, ready, fail, retries, lock_losses, state
   );

   modport slave (
      input  locked, restart,
      output pll_resetb, sys_reset, ready, fail, retries, lock_losses, state
   );
endinterface

// File: rtl/pll_supervisor.sv
// Bring-up sequencer for the iCE40 PLL: pulses RESETB, qualifies a stable lock,
// then releases the PLL-domain reset; retries on timeout, re-sequences on lock loss.
//
// state     | meaning
// RESET_PLL | pll_resetb held low for RESET_CYCLES
// WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT for lock
// STABLE    | lock seen, must hold STABLE_CYCLES consecutive cycles
// RUN       | system reset released, watching for lock loss
// FAIL      | retries exhausted, waits for restart or reset
module pll_supervisor #(
   parameter int RESET_CYCLES  = 4,
   parameter int LOCK_TIMEOUT  = 1000,
   parameter int STABLE_CYCLES = 16,
   parameter int MAX_RETRIES   = 3
) (
   input  logic             clock_in,
   input  logic             reset,
   pll_supervisor_if.slave  bus
);
   localparam int CMAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int CMAX   = (CMAX_A > STABLE_CYCLES) ? CMAX_A : STABLE_CYCLES;
   localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] RESET_TC  = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_TC = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_TC = CW'(STABLE_CYCLES - 1);
   localparam logic [3:0]    MAX_R     = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          meta_q, locked_s_q;
   logic [3:0]    retries_q, retries_d;
   logic [7:0]    losses_q, losses_d;
   logic          pll_resetb_q, pll_resetb_d;
   logic          sys_reset_q, sys_reset_d;
   logic          ready_q, ready_d;
   logic          fail_q, fail_d;

   always_ff @(posedge clock_in) begin
      if (reset) begin
         meta_q       <= 1'b0;
         locked_s_q   <= 1'b0;
         state_q      <= RESET_PLL;
         cnt_q        <= '0;
         retries_q    <= '0;
         losses_q     <= '0;
         pll_resetb_q <= 1'b0;
         sys_reset_q  <= 1'b1;
         ready_q      <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         meta_q       <= bus.locked;
         locked_s_q   <= meta_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retries_q    <= retries_d;
         losses_q     <= losses_d;
         pll_resetb_q <= pll_resetb_d;
         sys_reset_q  <= sys_reset_d;
         ready_q      <= ready_d;
         fail_q       <= fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      retries_d = retries_q;
      losses_d  = losses_q;
      if (bus.restart) begin
         state_d   = RESET_PLL;
         retries_d = '0;
      end else begin
         case (state_q)
            RESET_PLL: if (cnt_q == RESET_TC) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
               if (locked_s_q) begin
                  state_d = STABLE;
               end else if (cnt_q == TIMEOUT_TC) begin
                  if (retries_q + 4'd1 == MAX_R) begin
                     retries_d = MAX_R;
                     state_d   = FAIL;
                  end else begin
                     retries_d = retries_q + 4'd1;
                     state_d   = RESET_PLL;
                  end
               end
            end
            STABLE: begin
               if (!locked_s_q) begin
                  state_d = WAIT_LOCK;
               end else if (cnt_q == STABLE_TC) begin
                  state_d   = RUN;
                  retries_d = '0;
               end
            end
            RUN: begin
               if (!locked_s_q) begin
                  state_d  = RESET_PLL;
                  losses_d = (losses_q == 8'hFF) ? losses_q : losses_q + 8'd1;
               end
            end
            FAIL:    state_d = FAIL;
            default: state_d = RESET_PLL;
         endcase
      end

      // RUN and FAIL hold the counter so it can never wrap while parked
      if (bus.restart || (state_d != state_q)) begin
         cnt_d = '0;
      end else if ((state_q == RESET_PLL) || (state_q == WAIT_LOCK) || (state_q == STABLE)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end

      pll_resetb_d = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
      sys_reset_d  = (state_d != RUN);
      ready_d      = (state_d == RUN);
      fail_d       = (state_d == FAIL);
   end

   assign bus.state       = state_q;
   assign bus.pll_resetb  = pll_resetb_q;
   assign bus.sys_reset   = sys_reset_q;
   assign bus.ready       = ready_q;
   assign bus.fail        = fail_q;
   assign bus.retries     = retries_q;
   assign bus.lock_losses = losses_q;
endmodule

// File: tb/tb_pll_supervisor.sv
// Self-checking bench for pll_supervisor with default parameters: vector table plus
// hand-built timeout, exhaustion and saturation sequences, checked through a queue.
module tb_pll_supervisor;
   localparam logic [2:0] S_RST = 3'd0, S_WAIT = 3'd1, S_STB = 3'd2, S_RUN = 3'd3, S_FL = 3'd4;

   typedef struct {
      logic       rst, rs, lk;
      int         n;
      logic [2:0] st;
      logic       prb, srst, rdy, fl;
      logic [3:0] rt;
      logic [7:0] ll;
   } vec_t;

   typedef struct {
      int         id;
      logic [2:0] st;
      logic       prb, srst, rdy, fl;
      logic [3:0] rt;
      logic [7:0] ll;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   next_id = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   vec_t tbl[24];

   pll_supervisor_if bus();

   pll_supervisor dut (
      .clock_in (clk),
      .reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         total++;
         if (bus.state !== mon_e.st || bus.pll_resetb !== mon_e.prb || bus.sys_reset !== mon_e.srst ||
             bus.ready !== mon_e.rdy || bus.fail !== mon_e.fl || bus.retries !== mon_e.rt ||
             bus.lock_losses !== mon_e.ll) begin
            bad++;
            $display("FAIL chk%0d: got st=%0d prb=%b srst=%b rdy=%b fail=%b rt=%0d ll=%0d want st=%0d prb=%b srst=%b rdy=%b fail=%b rt=%0d ll=%0d",
                     mon_e.id, bus.state, bus.pll_resetb, bus.sys_reset, bus.ready, bus.fail, bus.retries,
                     bus.lock_losses, mon_e.st, mon_e.prb, mon_e.srst, mon_e.rdy, mon_e.fl, mon_e.rt, mon_e.ll);
         end
      end
   end

   function automatic vec_t mkv(input logic r, input logic s, input logic l, input int n,
                                input logic [2:0] st, input logic prb, input logic srst,
                                input logic rdy, input logic fl, input logic [3:0] rt,
                                input logic [7:0] ll);
      vec_t v;
      v.rst = r; v.rs = s; v.lk = l; v.n = n; v.st = st; v.prb = prb; v.srst = srst;
      v.rdy = rdy; v.fl = fl; v.rt = rt; v.ll = ll;
      return v;
   endfunction

   task automatic push_exp(input logic [2:0] st, input logic prb, input logic srst, input logic rdy,
                           input logic fl, input logic [3:0] rt, input logic [7:0] ll);
      exp_t e;
      e.id = next_id; e.st = st; e.prb = prb; e.srst = srst; e.rdy = rdy; e.fl = fl; e.rt = rt; e.ll = ll;
      next_id++;
      exp_q.push_back(e);
   endtask

   // Inputs change just after an edge; expectations describe outputs after the n-th following edge.
   task automatic step(input vec_t v);
      rst         = v.rst;
      bus.restart = v.rs;
      bus.locked  = v.lk;
      repeat (v.n) @(posedge clk);
      #1;
      push_exp(v.st, v.prb, v.srst, v.rdy, v.fl, v.rt, v.ll);
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, input string name);
      int k = 0;
      while (bus.state !== target && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      total++;
      if (bus.state !== target) begin
         bad++;
         $display("FAIL %s: state=%0d after %0d cycles, want %0d", name, bus.state, k, target);
      end
   endtask

   initial begin
      // nominal, lock loss, glitch, restart and reset priority
      tbl[0]  = mkv(1,0,0, 2, S_RST, 0,1,0,0,0,0);
      tbl[1]  = mkv(0,0,0, 3, S_RST, 0,1,0,0,0,0);
      tbl[2]  = mkv(0,0,0, 1, S_WAIT,1,1,0,0,0,0);
      tbl[3]  = mkv(0,0,0,20, S_WAIT,1,1,0,0,0,0);
      tbl[4]  = mkv(0,0,1, 2, S_WAIT,1,1,0,0,0,0);
      tbl[5]  = mkv(0,0,1, 1, S_STB, 1,1,0,0,0,0);
      tbl[6]  = mkv(0,0,1,15, S_STB, 1,1,0,0,0,0);
      tbl[7]  = mkv(0,0,1, 1, S_RUN, 1,0,1,0,0,0);
      tbl[8]  = mkv(0,0,0, 2, S_RUN, 1,0,1,0,0,0);
      tbl[9]  = mkv(0,0,0, 1, S_RST, 0,1,0,0,0,1);
      tbl[10] = mkv(0,0,0, 4, S_WAIT,1,1,0,0,0,1);
      tbl[11] = mkv(0,0,1, 3, S_STB, 1,1,0,0,0,1);
      tbl[12] = mkv(0,0,1, 5, S_STB, 1,1,0,0,0,1);
      tbl[13] = mkv(0,0,0, 1, S_STB, 1,1,0,0,0,1);
      tbl[14] = mkv(0,0,1, 1, S_STB, 1,1,0,0,0,1);
      tbl[15] = mkv(0,0,1, 1, S_WAIT,1,1,0,0,0,1);
      tbl[16] = mkv(0,0,1, 1, S_STB, 1,1,0,0,0,1);
      tbl[17] = mkv(0,0,1,15, S_STB, 1,1,0,0,0,1);
      tbl[18] = mkv(0,0,1, 1, S_RUN, 1,0,1,0,0,1);
      tbl[19] = mkv(0,1,1, 1, S_RST, 0,1,0,0,0,1);
      tbl[20] = mkv(0,0,1, 4, S_WAIT,1,1,0,0,0,1);
      tbl[21] = mkv(0,0,1, 1, S_STB, 1,1,0,0,0,1);
      tbl[22] = mkv(0,0,1,16, S_RUN, 1,0,1,0,0,1);
      tbl[23] = mkv(1,1,1, 1, S_RST, 0,1,0,0,0,0);

      bus.locked  = 1'b0;
      bus.restart = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 24; i++) step(tbl[i]);

      // timeout on the first attempt, lock 10 cycles into the second
      step(mkv(1,0,0,  1, S_RST, 0,1,0,0,0,0));
      step(mkv(0,0,0,  4, S_WAIT,1,1,0,0,0,0));
      step(mkv(0,0,0,999, S_WAIT,1,1,0,0,0,0));
      step(mkv(0,0,0,  1, S_RST, 0,1,0,0,1,0));
      step(mkv(0,0,0,  3, S_RST, 0,1,0,0,1,0));
      step(mkv(0,0,0,  1, S_WAIT,1,1,0,0,1,0));
      step(mkv(0,0,0, 10, S_WAIT,1,1,0,0,1,0));
      step(mkv(0,0,1,  2, S_WAIT,1,1,0,0,1,0));
      step(mkv(0,0,1,  1, S_STB, 1,1,0,0,1,0));
      step(mkv(0,0,1, 16, S_RUN, 1,0,1,0,0,0));

      // never locks: three timeouts then FAIL, which ignores a late lock
      step(mkv(1,0,0, 1, S_RST, 0,1,0,0,0,0));
      for (int a = 0; a < 3; a++) begin
         step(mkv(0,0,0, 4, S_WAIT,1,1,0,0,4'(a),0));
         if (a < 2) step(mkv(0,0,0,1000, S_RST,0,1,0,0,4'(a+1),0));
         else       step(mkv(0,0,0,1000, S_FL, 0,1,0,1,4'd3,0));
      end
      step(mkv(0,0,1,50, S_FL, 0,1,0,1,3,0));
      step(mkv(0,1,1, 1, S_RST,0,1,0,0,0,0));
      step(mkv(0,0,1, 1, S_RST,0,1,0,0,0,0));
      wait_state(S_RUN, 100, "relock_after_restart");

      // 256 lock drops in RUN; the loss counter saturates at 255
      for (int i = 0; i < 256; i++) begin
         bus.locked = 1'b0;
         wait_state(S_RST, 10, "drop_to_reset");
         bus.locked = 1'b1;
         wait_state(S_RUN, 100, "back_to_run");
         push_exp(S_RUN, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      end

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
